// File: rtl/spm_port_arbiter_pkg.sv
// spm_port_arbiter_pkg: shared strobe/rw polarities, widths and arbiter encodings
package spm_port_arbiter_pkg;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam int   WORD_W     = 32;
    localparam int   SPM_ADDR_W = 12;
    typedef enum logic [1:0] {
        SPM_ARB_IDLE   = 2'd0,
        SPM_ARB_ACCESS = 2'd1,
        SPM_ARB_DONE   = 2'd2
    } spm_arb_state_e;
    typedef enum logic {
        SPM_OWNER_MEM = 1'b0,
        SPM_OWNER_BUS = 1'b1
    } spm_owner_e;
endpackage

// File: rtl/spm_port_arbiter.sv
// spm_port_arbiter: shares SPM port B between MEM stage and bus master in 3-cycle transactions,
// MEM first with a starvation counter forcing a bus grant after STARVE_LIMIT losses.
module spm_port_arbiter
    import spm_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  mem_as_,
    input  logic                  mem_rw,
    input  logic [SPM_ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0]     mem_wr_data,
    output logic [WORD_W-1:0]     mem_rd_data,
    output logic                  mem_rdy_,
    input  logic                  bus_as_,
    input  logic                  bus_rw,
    input  logic [SPM_ADDR_W-1:0] bus_addr,
    input  logic [WORD_W-1:0]     bus_wr_data,
    output logic [WORD_W-1:0]     bus_rd_data,
    output logic                  bus_rdy_,
    output logic                  spm_as_,
    output logic                  spm_rw,
    output logic [SPM_ADDR_W-1:0] spm_addr,
    output logic [WORD_W-1:0]     spm_wr_data,
    input  logic [WORD_W-1:0]     spm_rd_data
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    spm_arb_state_e        state;
    spm_owner_e            owner;
    logic                  cmd_rw;
    logic [SPM_ADDR_W-1:0] cmd_addr;
    logic [WORD_W-1:0]     cmd_wr_data;
    logic [3:0]            starve_cnt;
    logic                  mem_req, bus_req, bus_win, access, mem_done, bus_done;
    assign mem_req = mem_as_ == ENABLE_;
    assign bus_req = bus_as_ == ENABLE_;
    assign bus_win = bus_req && (!mem_req || starve_cnt == LIMIT);
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state       <= SPM_ARB_IDLE;
            owner       <= SPM_OWNER_MEM;
            cmd_rw      <= 1'b0;
            cmd_addr    <= '0;
            cmd_wr_data <= '0;
            starve_cnt  <= '0;
        end else begin
            case (state)
                SPM_ARB_IDLE: if (mem_req || bus_req) begin
                    state       <= SPM_ARB_ACCESS;
                    owner       <= bus_win ? SPM_OWNER_BUS : SPM_OWNER_MEM;
                    cmd_rw      <= bus_win ? bus_rw : mem_rw;
                    cmd_addr    <= bus_win ? bus_addr : mem_addr;
                    cmd_wr_data <= bus_win ? bus_wr_data : mem_wr_data;
                    starve_cnt  <= bus_win ? 4'd0 : bus_req ? starve_cnt + 4'd1 : starve_cnt;
                end
                SPM_ARB_ACCESS: state <= SPM_ARB_DONE;
                default:        state <= SPM_ARB_IDLE;
            endcase
        end
    end
    assign access      = state == SPM_ARB_ACCESS;
    assign mem_done    = state == SPM_ARB_DONE && owner == SPM_OWNER_MEM;
    assign bus_done    = state == SPM_ARB_DONE && owner == SPM_OWNER_BUS;
    assign spm_as_     = access ? ENABLE_ : DISABLE_;
    assign spm_rw      = access ? cmd_rw : READ;
    assign spm_addr    = access ? cmd_addr : '0;
    assign spm_wr_data = access ? cmd_wr_data : '0;
    assign mem_rdy_    = mem_done ? ENABLE_ : DISABLE_;
    assign bus_rdy_    = bus_done ? ENABLE_ : DISABLE_;
    assign mem_rd_data = mem_done ? spm_rd_data : '0;
    assign bus_rd_data = bus_done ? spm_rd_data : '0;
endmodule

// File: tb/tb_spm_port_arbiter.sv
// tb_spm_port_arbiter: directed checks of arbitration, latency, starvation and async reset
module tb_spm_port_arbiter;
    import spm_port_arbiter_pkg::*;
    logic        clk = 1'b0;
    logic        reset_;
    logic        mem_as_, mem_rw, bus_as_, bus_rw;
    logic [11:0] mem_addr, bus_addr, spm_addr;
    logic [31:0] mem_wr_data, bus_wr_data, mem_rd_data, bus_rd_data, spm_wr_data, spm_rd_data;
    logic        mem_rdy_, bus_rdy_, spm_as_, spm_rw;
    logic [31:0] ram [4096];
    logic        preloaded = 1'b0;
    logic [9:0]  exp_bus;
    int          n_vec = 0;
    int          n_err = 0;
    always #5 clk = ~clk;
    spm_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_(reset_),
        .mem_as_(mem_as_), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_rdy_(mem_rdy_),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
        .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_addr(spm_addr), .spm_wr_data(spm_wr_data),
        .spm_rd_data(spm_rd_data)
    );
    // RAM with registered read port; contents preloaded on the first edge
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int k = 0; k < 4; k++) ram[k] = 32'hA5A50000 + 32'(k);
            ram[12'hFFF] = 32'h12345678;
            preloaded = 1'b1;
        end
        if (spm_as_ == ENABLE_) begin
            spm_rd_data <= ram[spm_addr];
            if (spm_rw == WRITE) ram[spm_addr] = spm_wr_data;
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic mem_txn(input logic rw, input logic [11:0] a, input logic [31:0] d, input logic [31:0] exp);
        mem_as_ = ENABLE_; mem_rw = rw; mem_addr = a; mem_wr_data = d;
        tick;
        chk("mem_access_as", 32'(spm_as_), 32'(ENABLE_));
        chk("mem_access_addr", 32'(spm_addr), 32'(a));
        chk("mem_access_rw", 32'(spm_rw), 32'(rw));
        chk("mem_access_rdy", 32'(mem_rdy_), 32'(DISABLE_));
        tick;
        chk("mem_done_rdy", 32'(mem_rdy_), 32'(ENABLE_));
        chk("mem_done_bus_rdy", 32'(bus_rdy_), 32'(DISABLE_));
        if (rw == READ) chk("mem_done_data", mem_rd_data, exp);
        mem_as_ = DISABLE_;
        tick;
        chk("mem_idle_rdy", 32'(mem_rdy_), 32'(DISABLE_));
        chk("mem_idle_as", 32'(spm_as_), 32'(DISABLE_));
    endtask
    initial begin
        reset_ = 1'b0;
        mem_as_ = DISABLE_; mem_rw = READ; mem_addr = '0; mem_wr_data = '0;
        bus_as_ = DISABLE_; bus_rw = READ; bus_addr = '0; bus_wr_data = '0;
        #2;
        chk("rst_spm_as", 32'(spm_as_), 32'(DISABLE_));
        chk("rst_mem_rdy", 32'(mem_rdy_), 32'(DISABLE_));
        chk("rst_bus_rdy", 32'(bus_rdy_), 32'(DISABLE_));
        chk("rst_spm_addr", 32'(spm_addr), 32'h0);
        chk("rst_mem_rd", mem_rd_data, 32'h0);
        tick;
        reset_ = 1'b1;
        tick;
        mem_txn(WRITE, 12'h010, 32'hDEADBEEF, 32'h0);
        mem_txn(READ, 12'h010, 32'h0, 32'hDEADBEEF);
        bus_as_ = ENABLE_; bus_rw = READ; bus_addr = 12'hFFF;
        tick;
        chk("bus_access_as", 32'(spm_as_), 32'(ENABLE_));
        chk("bus_access_addr", 32'(spm_addr), 32'hFFF);
        chk("bus_access_mem_rd", mem_rd_data, 32'h0);
        tick;
        chk("bus_done_rdy", 32'(bus_rdy_), 32'(ENABLE_));
        chk("bus_done_data", bus_rd_data, 32'h12345678);
        chk("bus_done_mem_rd", mem_rd_data, 32'h0);
        chk("bus_done_mem_rdy", 32'(mem_rdy_), 32'(DISABLE_));
        bus_as_ = DISABLE_;
        tick;
        chk("bus_idle_rdy", 32'(bus_rdy_), 32'(DISABLE_));
        chk("bus_idle_data", bus_rd_data, 32'h0);
        for (int i = 0; i < 4; i++) mem_txn(READ, 12'(i), 32'h0, 32'hA5A50000 + 32'(i));
        exp_bus = 10'b1000010000;
        mem_as_ = ENABLE_; mem_rw = READ; mem_addr = 12'h010;
        bus_as_ = ENABLE_; bus_rw = READ; bus_addr = 12'hFFF;
        for (int i = 0; i < 10; i++) begin
            tick;
            tick;
            chk($sformatf("cont%0d_mem_rdy", i), 32'(mem_rdy_), exp_bus[i] ? 32'(DISABLE_) : 32'(ENABLE_));
            chk($sformatf("cont%0d_bus_rdy", i), 32'(bus_rdy_), exp_bus[i] ? 32'(ENABLE_) : 32'(DISABLE_));
            chk($sformatf("cont%0d_data", i), exp_bus[i] ? bus_rd_data : mem_rd_data,
                exp_bus[i] ? 32'h12345678 : 32'hDEADBEEF);
            chk($sformatf("cont%0d_starve", i), 32'(dut.starve_cnt), (i % 5 == 4) ? 32'd0 : 32'(i % 5 + 1));
            if (i == 9) begin
                mem_as_ = DISABLE_;
                bus_as_ = DISABLE_;
            end
            tick;
        end
        bus_as_ = ENABLE_; bus_rw = READ; bus_addr = 12'hFFF;
        tick;
        chk("rstmid_access_as", 32'(spm_as_), 32'(ENABLE_));
        #2 reset_ = 1'b0;
        #1;
        chk("rstmid_spm_as", 32'(spm_as_), 32'(DISABLE_));
        chk("rstmid_spm_addr", 32'(spm_addr), 32'h0);
        chk("rstmid_bus_rdy", 32'(bus_rdy_), 32'(DISABLE_));
        bus_as_ = DISABLE_;
        tick;
        chk("rstmid_no_rdy", 32'(bus_rdy_), 32'(DISABLE_));
        chk("rstmid_no_data", bus_rd_data, 32'h0);
        reset_ = 1'b1;
        tick;
        chk("rstmid_idle_as", 32'(spm_as_), 32'(DISABLE_));
        mem_txn(READ, 12'h010, 32'h0, 32'hDEADBEEF);
        mem_as_ = ENABLE_; mem_rw = READ; mem_addr = 12'h003;
        tick;
        chk("drop_access_as", 32'(spm_as_), 32'(ENABLE_));
        mem_as_ = DISABLE_;
        tick;
        chk("drop_done_rdy", 32'(mem_rdy_), 32'(ENABLE_));
        chk("drop_done_data", mem_rd_data, 32'hA5A50003);
        tick;
        chk("drop_idle_rdy", 32'(mem_rdy_), 32'(DISABLE_));
        tick;
        chk("drop_no_grant", 32'(spm_as_), 32'(DISABLE_));
        chk("drop_no_rdy", 32'(mem_rdy_), 32'(DISABLE_));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
